// File: rtl/imm_pkg.sv
// Shared constants for the immediate/target generator: format codes,
// RV32I major opcodes and the default datapath width.
package imm_pkg;

  localparam int XLEN_DEFAULT = 32;

  // Format codes presented on out_fmt
  localparam logic [2:0] FMT_R    = 3'd0;
  localparam logic [2:0] FMT_I    = 3'd1;
  localparam logic [2:0] FMT_S    = 3'd2;
  localparam logic [2:0] FMT_B    = 3'd3;
  localparam logic [2:0] FMT_U    = 3'd4;
  localparam logic [2:0] FMT_J    = 3'd5;
  localparam logic [2:0] FMT_NONE = 3'd7;

  // RV32I major opcodes (instr[6:0])
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_OPIMM  = 7'b0010011;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_OP     = 7'b0110011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

endpackage

// File: rtl/imm_decode.sv
// Combinational decoder: classifies the instruction format from the opcode,
// extracts and sign-extends the immediate, and forms the pc-relative target.
// Optional build macro: IMM_MISALIGN_EN adds the misaligned-target flag.
module imm_decode
  import imm_pkg::*;
#(
  parameter int XLEN = XLEN_DEFAULT
) (
  input  logic [31:0]     instr_i,
  input  logic [XLEN-1:0] pc_i,
  output logic [2:0]      fmt_o,
  output logic [XLEN-1:0] imm_o,
  output logic [XLEN-1:0] target_o,
`ifdef IMM_MISALIGN_EN
  output logic            misalign_o,
`endif
  output logic            illegal_o
);

  logic [6:0]  opcode;
  logic [31:0] imm32;
  logic        pcRelative;

  // Opcode classification and raw 32-bit immediate assembly; JALR is treated
  // as a plain I-type because rs1 is not visible here, so its target is pc+4
  always_comb begin
    opcode     = instr_i[6:0];
    imm32      = 32'd0;
    fmt_o      = FMT_NONE;
    illegal_o  = 1'b0;
    pcRelative = 1'b0;
    case (opcode)
      OP_OPIMM, OP_LOAD, OP_JALR, OP_SYSTEM: begin
        fmt_o = FMT_I;
        imm32 = {{20{instr_i[31]}}, instr_i[31:20]};
      end
      OP_STORE: begin
        fmt_o = FMT_S;
        imm32 = {{20{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
      end
      OP_BRANCH: begin
        fmt_o      = FMT_B;
        pcRelative = 1'b1;
        imm32      = {{19{instr_i[31]}}, instr_i[31], instr_i[7],
                      instr_i[30:25], instr_i[11:8], 1'b0};
      end
      OP_LUI: begin
        fmt_o = FMT_U;
        imm32 = {instr_i[31:12], 12'd0};
      end
      OP_AUIPC: begin
        fmt_o      = FMT_U;
        pcRelative = 1'b1;
        imm32      = {instr_i[31:12], 12'd0};
      end
      OP_JAL: begin
        fmt_o      = FMT_J;
        pcRelative = 1'b1;
        imm32      = {{11{instr_i[31]}}, instr_i[31], instr_i[19:12],
                      instr_i[20], instr_i[30:21], 1'b0};
      end
      OP_OP: begin
        fmt_o = FMT_R;
      end
      default: begin
        illegal_o = 1'b1;
      end
    endcase
  end

  // Widen to XLEN by sign extension from bit 31, then form the target;
  // the add wraps naturally at XLEN bits
  always_comb begin
    imm_o    = XLEN'($signed(imm32));
    target_o = pc_i + (pcRelative ? imm_o : XLEN'(4));
  end

`ifdef IMM_MISALIGN_EN
  // Control-transfer targets must be word aligned in a core without compressed instructions
  always_comb begin
    misalign_o = ((fmt_o == FMT_B) || (fmt_o == FMT_J)) && (target_o[1:0] != 2'b00);
  end
`endif

endmodule

// File: rtl/imm_gen_pipe.sv
// Buffered immediate/target generator: decodes {instr, pc} on accept and
// holds the results in a DEPTH-entry FIFO with valid/ready on both sides.
// Optional build macro: IMM_MISALIGN_EN adds out_misalign per entry.
module imm_gen_pipe
  import imm_pkg::*;
#(
  parameter int XLEN  = XLEN_DEFAULT,
  parameter int DEPTH = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [31:0]            in_instr,
  input  logic [XLEN-1:0]        in_pc,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [2:0]             out_fmt,
  output logic [XLEN-1:0]        out_imm,
  output logic [XLEN-1:0]        out_target,
  output logic                   out_illegal,
`ifdef IMM_MISALIGN_EN
  output logic                   out_misalign,
`endif
  output logic [$clog2(DEPTH):0] out_count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [2:0]      decFmt;
  logic [XLEN-1:0] decImm;
  logic [XLEN-1:0] decTarget;
  logic            decIllegal;

  logic [2:0]      fmtMem     [DEPTH];
  logic [XLEN-1:0] immMem     [DEPTH];
  logic [XLEN-1:0] targetMem  [DEPTH];
  logic            illegalMem [DEPTH];

  logic [PW-1:0] headPtr_q, headPtr_d;
  logic [PW-1:0] tailPtr_q, tailPtr_d;
  logic [CW-1:0] count_q, count_d;
  logic          push;
  logic          pop;

`ifdef IMM_MISALIGN_EN
  logic decMisalign;
  logic misalignMem [DEPTH];
`endif

  imm_decode #(.XLEN(XLEN)) uDecode (
    .instr_i    (in_instr),
    .pc_i       (in_pc),
    .fmt_o      (decFmt),
    .imm_o      (decImm),
    .target_o   (decTarget),
`ifdef IMM_MISALIGN_EN
    .misalign_o (decMisalign),
`endif
    .illegal_o  (decIllegal)
  );

  // Handshake: readiness depends only on registered count plus rst/flush,
  // so there is no combinational path from out_ready back to in_ready
  always_comb begin
    out_valid = (count_q != '0);
    in_ready  = !rst && !flush && (count_q < CW'(DEPTH));
    push      = in_valid && in_ready;
    pop       = out_valid && out_ready && !flush;
  end

  // Pointer and occupancy next-state; flush empties the FIFO and drops any pop
  always_comb begin
    headPtr_d = headPtr_q;
    tailPtr_d = tailPtr_q;
    count_d   = count_q;
    if (flush) begin
      headPtr_d = '0;
      tailPtr_d = '0;
      count_d   = '0;
    end else begin
      if (push) tailPtr_d = tailPtr_q + PW'(1);
      if (pop)  headPtr_d = headPtr_q + PW'(1);
      count_d = count_q + CW'(push) - CW'(pop);
    end
  end

  // Control state registers; reset wins over flush and any handshake
  always_ff @(posedge clk) begin
    if (rst) begin
      headPtr_q <= '0;
      tailPtr_q <= '0;
      count_q   <= '0;
    end else begin
      headPtr_q <= headPtr_d;
      tailPtr_q <= tailPtr_d;
      count_q   <= count_d;
    end
  end

  // Entry storage is written only on accept; stale contents are never visible
  // because the outputs are gated by out_valid
  always_ff @(posedge clk) begin
    if (push) begin
      fmtMem[tailPtr_q]     <= decFmt;
      immMem[tailPtr_q]     <= decImm;
      targetMem[tailPtr_q]  <= decTarget;
      illegalMem[tailPtr_q] <= decIllegal;
`ifdef IMM_MISALIGN_EN
      misalignMem[tailPtr_q] <= decMisalign;
`endif
    end
  end

  // Head entry presentation, forced to zero whenever the FIFO is empty
  always_comb begin
    out_fmt     = out_valid ? fmtMem[headPtr_q]     : 3'd0;
    out_imm     = out_valid ? immMem[headPtr_q]     : '0;
    out_target  = out_valid ? targetMem[headPtr_q]  : '0;
    out_illegal = out_valid ? illegalMem[headPtr_q] : 1'b0;
    out_count   = count_q;
`ifdef IMM_MISALIGN_EN
    out_misalign = out_valid ? misalignMem[headPtr_q] : 1'b0;
`endif
  end

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Directed self-checking bench for imm_gen_pipe (XLEN=32, DEPTH=2).
// Optional build macro: IMM_MISALIGN_EN enables the misalign checks.
module tb_imm_gen_pipe;

  localparam int XLEN  = 32;
  localparam int DEPTH = 2;

  logic            clk = 1'b0;
  logic            rst;
  logic            flush;
  logic            in_valid;
  logic            in_ready;
  logic [31:0]     in_instr;
  logic [XLEN-1:0] in_pc;
  logic            out_valid;
  logic            out_ready;
  logic [2:0]      out_fmt;
  logic [XLEN-1:0] out_imm;
  logic [XLEN-1:0] out_target;
  logic            out_illegal;
  logic [1:0]      out_count;
`ifdef IMM_MISALIGN_EN
  logic            out_misalign;
`endif

  int compared   = 0;
  int mismatched = 0;

  imm_gen_pipe #(.XLEN(XLEN), .DEPTH(DEPTH)) dut (
    .clk         (clk),
    .rst         (rst),
    .flush       (flush),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_instr    (in_instr),
    .in_pc       (in_pc),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_fmt     (out_fmt),
    .out_imm     (out_imm),
    .out_target  (out_target),
    .out_illegal (out_illegal),
`ifdef IMM_MISALIGN_EN
    .out_misalign(out_misalign),
`endif
    .out_count   (out_count)
  );

  // Free-running clock
  always #5 clk = ~clk;

  // Watchdog so the run always ends even if the stimulus stalls
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: observed timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    compared++;
    assert (observed === expected) else begin
      mismatched++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic valid, input logic [31:0] instr, input logic [XLEN-1:0] pc);
    in_valid = valid;
    in_instr = instr;
    in_pc    = pc;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Push one instruction with out_ready high, check the head, let it pop
  task automatic decodeVector(input string tag, input logic [31:0] instr, input logic [XLEN-1:0] pc,
                              input logic [2:0] expFmt, input logic [XLEN-1:0] expImm,
                              input logic [XLEN-1:0] expTarget, input logic expIllegal,
                              input logic expMisalign);
    out_ready = 1'b1;
    applyStimulus(1'b1, instr, pc);
    tick();
    applyStimulus(1'b0, 32'd0, '0);
    checkOutput({tag, ".valid"},   {63'd0, out_valid},   64'd1);
    checkOutput({tag, ".fmt"},     {61'd0, out_fmt},     {61'd0, expFmt});
    checkOutput({tag, ".imm"},     {32'd0, out_imm},     {32'd0, expImm});
    checkOutput({tag, ".target"},  {32'd0, out_target},  {32'd0, expTarget});
    checkOutput({tag, ".illegal"}, {63'd0, out_illegal}, {63'd0, expIllegal});
`ifdef IMM_MISALIGN_EN
    checkOutput({tag, ".misalign"}, {63'd0, out_misalign}, {63'd0, expMisalign});
`else
    if (expMisalign) begin end
`endif
    tick();
    checkOutput({tag, ".drained"}, {62'd0, out_count}, 64'd0);
  endtask

  initial begin
    rst = 1'b1;
    flush = 1'b0;
    out_ready = 1'b0;
    applyStimulus(1'b0, 32'd0, '0);

    // Reset state
    #1;
    checkOutput("rst.in_ready_low", {63'd0, in_ready}, 64'd0);
    tick();
    checkOutput("rst.count",     {62'd0, out_count}, 64'd0);
    checkOutput("rst.out_valid", {63'd0, out_valid}, 64'd0);
    checkOutput("rst.out_imm",   {32'd0, out_imm},   64'd0);
    checkOutput("rst.in_ready_held", {63'd0, in_ready}, 64'd0);
    rst = 1'b0;
    #1;
    checkOutput("rst.in_ready_after", {63'd0, in_ready}, 64'd1);

    // Decode vectors through the FIFO
    decodeVector("addi",  32'hFFF00093, 32'h100,      3'd1, 32'hFFFFFFFF, 32'h104,      1'b0, 1'b0);
    decodeVector("beq",   32'hFE000EE3, 32'h200,      3'd3, 32'hFFFFFFFC, 32'h1FC,      1'b0, 1'b0);
    decodeVector("jal",   32'h0080006F, 32'hFFFFFFFC, 3'd5, 32'h8,        32'h4,        1'b0, 1'b0);
    decodeVector("sw",    32'h00112623, 32'h20,       3'd2, 32'hC,        32'h24,       1'b0, 1'b0);
    decodeVector("lui",   32'h12345037, 32'h40,       3'd4, 32'h12345000, 32'h44,       1'b0, 1'b0);
    decodeVector("auipc", 32'h80000017, 32'h10,       3'd4, 32'h80000000, 32'h80000010, 1'b0, 1'b0);
    decodeVector("add",   32'h002081B3, 32'h60,       3'd0, 32'h0,        32'h64,       1'b0, 1'b0);
    decodeVector("jalr",  32'h00008067, 32'h500,      3'd1, 32'h0,        32'h504,      1'b0, 1'b0);
    decodeVector("bad",   32'h0000007F, 32'h300,      3'd7, 32'h0,        32'h304,      1'b1, 1'b0);
    decodeVector("jalmis",32'h0020006F, 32'h0,        3'd5, 32'h2,        32'h2,        1'b0, 1'b1);

    // Back-pressure: fill, hold C upstream, then drain in order
    out_ready = 1'b0;
    applyStimulus(1'b1, 32'hFFF00093, 32'h100);
    tick();
    checkOutput("bp.countA", {62'd0, out_count}, 64'd1);
    checkOutput("bp.readyA", {63'd0, in_ready},  64'd1);
    applyStimulus(1'b1, 32'hFE000EE3, 32'h200);
    tick();
    checkOutput("bp.countB", {62'd0, out_count}, 64'd2);
    checkOutput("bp.fullReady", {63'd0, in_ready}, 64'd0);
    checkOutput("bp.headA", {32'd0, out_imm}, 64'hFFFFFFFF);
    applyStimulus(1'b1, 32'h0080006F, 32'hFFFFFFFC);
    tick();
    checkOutput("bp.heldC", {62'd0, out_count}, 64'd2);
    checkOutput("bp.headA2", {32'd0, out_target}, 64'h104);
    out_ready = 1'b1;
    tick();
    checkOutput("bp.popA.count", {62'd0, out_count}, 64'd1);
    checkOutput("bp.popA.headB", {61'd0, out_fmt}, 64'd3);
    tick();
    checkOutput("bp.pushpop.count", {62'd0, out_count}, 64'd1);
    checkOutput("bp.headC.fmt", {61'd0, out_fmt}, 64'd5);
    checkOutput("bp.headC.target", {32'd0, out_target}, 64'h4);
    applyStimulus(1'b0, 32'd0, '0);
    tick();
    checkOutput("bp.empty.count", {62'd0, out_count}, 64'd0);
    checkOutput("bp.empty.valid", {63'd0, out_valid}, 64'd0);

    // Flush on a full FIFO with a concurrent input and pop
    out_ready = 1'b0;
    applyStimulus(1'b1, 32'hFFF00093, 32'h100);
    tick();
    applyStimulus(1'b1, 32'hFE000EE3, 32'h200);
    tick();
    checkOutput("fl.full", {62'd0, out_count}, 64'd2);
    flush = 1'b1;
    out_ready = 1'b1;
    applyStimulus(1'b1, 32'h0080006F, 32'hFFFFFFFC);
    #1;
    checkOutput("fl.in_ready", {63'd0, in_ready}, 64'd0);
    tick();
    flush = 1'b0;
    out_ready = 1'b0;
    applyStimulus(1'b0, 32'd0, '0);
    checkOutput("fl.count", {62'd0, out_count}, 64'd0);
    checkOutput("fl.valid", {63'd0, out_valid}, 64'd0);
    checkOutput("fl.target", {32'd0, out_target}, 64'd0);
    applyStimulus(1'b1, 32'h12345037, 32'h40);
    tick();
    applyStimulus(1'b0, 32'd0, '0);
    checkOutput("fl.refill.count", {62'd0, out_count}, 64'd1);
    checkOutput("fl.refill.fmt", {61'd0, out_fmt}, 64'd4);

    // Reset in mid-stream with input presented
    applyStimulus(1'b1, 32'hFFF00093, 32'h100);
    rst = 1'b1;
    #1;
    checkOutput("mrst.in_ready", {63'd0, in_ready}, 64'd0);
    tick();
    checkOutput("mrst.count", {62'd0, out_count}, 64'd0);
    checkOutput("mrst.valid", {63'd0, out_valid}, 64'd0);
    checkOutput("mrst.imm", {32'd0, out_imm}, 64'd0);
    rst = 1'b0;
    applyStimulus(1'b0, 32'd0, '0);
    #1;
    checkOutput("mrst.in_ready_after", {63'd0, in_ready}, 64'd1);
    applyStimulus(1'b1, 32'h002081B3, 32'h60);
    tick();
    applyStimulus(1'b0, 32'd0, '0);
    checkOutput("mrst.push.count", {62'd0, out_count}, 64'd1);
    checkOutput("mrst.push.target", {32'd0, out_target}, 64'h64);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
